fft16_frame_loader: RTL and testbench

//  Upstream stage of FFT16. Gathers a continuous stream of complex samples
//  {imag,real} into 16-sample frames. Uses a two-bank ping-pong buffer.

---
 rtl/fft16_frame_loader.sv | 65 ++++++
 tb/tb_fft16_frame_loader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fft16_frame_loader.sv
// fft16_frame_loader: ping-pong gather of a complex sample stream into 16-lane frames for FFT16
// Optional dropped-sample counter: define FFT16_LDR_OVFCNT_EN.
module fft16_frame_loader #(
  parameter int DW = 16,
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [2*DW-1:0]   s_data,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [N*2*DW-1:0] frm_data,
  output logic              ovf,
  output logic [15:0]       ovf_cnt
);
  logic [2*DW-1:0] mem [2][N];
  logic [1:0] full, full_n;
  logic wr_bank, rd_bank, wr, drop, acc, last;
  logic [IW-1:0] wr_idx;
  assign frm_valid = full[rd_bank];
  // set and clear never hit the same bank: a write needs a non-full bank, an accept a full one
  always_comb begin
    drop   = s_valid & full[wr_bank];
    wr     = s_valid & ~full[wr_bank];
    acc    = frm_valid & frm_ready;
    last   = wr & (wr_idx == IW'(N-1));
    full_n = (full & ~(acc ? (2'b01 << rd_bank) : 2'b00)) | (last ? (2'b01 << wr_bank) : 2'b00);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      ovf     <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++)
          mem[b][i] <= '0;
    end else begin
      full <= full_n;
      ovf  <= drop;
      if (wr) begin
        mem[wr_bank][wr_idx] <= s_data;
        wr_idx  <= wr_idx + 1'b1;
        wr_bank <= wr_bank ^ last;
      end
      if (acc) rd_bank <= ~rd_bank;
    end
  end
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign frm_data[k*2*DW +: 2*DW] = mem[rd_bank][k];
  end
`ifdef FFT16_LDR_OVFCNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (drop && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
  end
  assign ovf_cnt = cnt;
`else
  assign ovf_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fft16_frame_loader.sv
// tb_fft16_frame_loader: scoreboard plus table-driven and directed checks for fft16_frame_loader
module tb_fft16_frame_loader;
  logic clk = 1'b0, rst = 1'b0, s_valid = 1'b0, frm_ready = 1'b0;
  logic [31:0] s_data = '0;
  logic frm_valid, ovf;
  logic [511:0] frm_data;
  logic [15:0] ovf_cnt;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  logic [511:0] q[$];
  logic [31:0] part[$];
  logic [511:0] f;
  bit m_ovf = 0, m_drop, m_acc;
  logic [15:0] m_cnt = '0;
  int nv, no;
  typedef struct {logic [31:0] smp; logic [31:0] lane;} vec_t;
  vec_t vec [16];

  fft16_frame_loader dut (.clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_data(frm_data), .ovf(ovf), .ovf_cnt(ovf_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit r);
    s_valid = v; s_data = d; frm_ready = r;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef FFT16_LDR_OVFCNT_EN
    return m_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  // reference model: full-state decisions use the pending-frame count before this edge's accept
  always @(posedge clk) begin
    if (rst) begin
      q.delete(); part.delete(); m_ovf = 0; m_cnt = '0;
    end else begin
      m_drop = s_valid && q.size() == 2;
      m_acc  = q.size() > 0 && frm_ready;
      m_ovf  = m_drop;
      if (m_drop && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
      if (m_acc) void'(q.pop_front());
      if (s_valid && !m_drop) begin
        part.push_back(s_data);
        if (part.size() == 16) begin
          for (int k = 0; k < 16; k++) f[32*k +: 32] = part[k];
          q.push_back(f);
          part.delete();
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("sb_valid", 512'(frm_valid), 512'(q.size() > 0));
    if (q.size() > 0 && frm_valid) chk("sb_data", frm_data, q[0]);
    chk("sb_ovf", 512'(ovf), 512'(m_ovf));
    chk("sb_ovf_cnt", 512'(ovf_cnt), 512'(exp_cnt()));
  end

  initial begin
    vec[0]  = '{32'h0000_0000, 32'h0000_0000}; vec[1]  = '{32'h0000_187D, 32'h0000_187D};
    vec[2]  = '{32'h0000_2D40, 32'h0000_2D40}; vec[3]  = '{32'h0000_3B1F, 32'h0000_3B1F};
    vec[4]  = '{32'h0000_3FFF, 32'h0000_3FFF}; vec[5]  = '{32'h0000_3B1F, 32'h0000_3B1F};
    vec[6]  = '{32'h0000_2D40, 32'h0000_2D40}; vec[7]  = '{32'h0000_187D, 32'h0000_187D};
    vec[8]  = '{32'h0000_0000, 32'h0000_0000}; vec[9]  = '{32'h0000_E783, 32'h0000_E783};
    vec[10] = '{32'h0000_D2C0, 32'h0000_D2C0}; vec[11] = '{32'h0000_C4E1, 32'h0000_C4E1};
    vec[12] = '{32'h0000_C001, 32'h0000_C001}; vec[13] = '{32'h0000_C4E1, 32'h0000_C4E1};
    vec[14] = '{32'h0000_D2C0, 32'h0000_D2C0}; vec[15] = '{32'h0000_E783, 32'h0000_E783};
    rst = 1'b1;
    step(0, 0, 0); step(0, 0, 0);
    rst = 1'b0;
    chk("rst_valid", 512'(frm_valid), 512'(0));
    chk("rst_data", frm_data, 512'(0));
    chk("rst_ovf", 512'(ovf), 512'(0));
    chk("rst_ovf_cnt", 512'(ovf_cnt), 512'(0));
    chk_en = 1;
    // T1: sine frame, held with ready low so every lane can be compared from the table
    for (int i = 0; i < 16; i++) begin
      step(1, vec[i].smp, 0);
      if (i < 15) chk("t1_early_valid", 512'(frm_valid), 512'(0));
    end
    s_valid = 0;
    chk("t1_latency", 512'(frm_valid), 512'(1));
    for (int k = 0; k < 16; k++) chk($sformatf("t1_lane%0d", k), 512'(frm_data[32*k +: 32]), 512'(vec[k].lane));
    step(0, 0, 1); step(0, 0, 0);
    chk("t1_released", 512'(frm_valid), 512'(0));
    // T2: 40-cycle stream with no consumer
    no = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 32'h0002_0000 + i, 0);
      no += int'(ovf);
      if (frm_valid) chk("t2_hold", 512'(frm_data[31:0]), 512'(32'h0002_0000));
    end
    chk("t2_ovf_pulses", 512'(no), 512'(8));
`ifdef FFT16_LDR_OVFCNT_EN
    chk("t2_ovf_cnt", 512'(ovf_cnt), 512'(8));
`else
    chk("t2_ovf_cnt", 512'(ovf_cnt), 512'(0));
`endif
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    // T3: back-to-back ramp, consumer always ready
    nv = 0; no = 0;
    for (int i = 0; i < 66; i++) begin
      step(i < 64, i, 1);
      nv += int'(frm_valid); no += int'(ovf);
    end
    chk("t3_frames", 512'(nv), 512'(4));
    chk("t3_no_ovf", 512'(no), 512'(0));
    // T4: reset mid-frame discards the partial frame
    for (int i = 0; i < 7; i++) step(1, 32'hDEAD_0000 + i, 0);
    rst = 1'b1; step(0, 0, 0); rst = 1'b0;
    chk("t4_rst_valid", 512'(frm_valid), 512'(0));
    for (int i = 0; i < 16; i++) step(1, 32'h100 + i, 0);
    s_valid = 0;
    chk("t4_valid", 512'(frm_valid), 512'(1));
    chk("t4_lane0", 512'(frm_data[31:0]), 512'(32'h0000_0100));
    chk("t4_lane15", 512'(frm_data[511:480]), 512'(32'h0000_010F));
    step(0, 0, 1);
    // T5: both banks full, accept and sample in the same cycle
    for (int i = 0; i < 32; i++) step(1, 32'h0005_0000 + i, 0);
    step(1, 32'hBAD0_BAD0, 1);
    chk("t5_ovf", 512'(ovf), 512'(1));
    chk("t5_valid", 512'(frm_valid), 512'(1));
    chk("t5_lane0", 512'(frm_data[31:0]), 512'(32'h0005_0010));
    step(0, 0, 1); step(0, 0, 0);
    chk("t5_drained", 512'(frm_valid), 512'(0));
    // T6: long overflow run must saturate the counter
    rst = 1'b1; step(0, 0, 0); rst = 1'b0;
    for (int i = 0; i < 32; i++) step(1, i, 0);
    for (int i = 0; i < 70000; i++) step(1, i, 0);
`ifdef FFT16_LDR_OVFCNT_EN
    chk("t6_sat", 512'(ovf_cnt), 512'(16'hFFFF));
`else
    chk("t6_sat", 512'(ovf_cnt), 512'(16'h0000));
`endif
    step(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
